// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the default MDU watchdog limit.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load still sitting in ID/EX (x0 never creates a hazard).
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  output logic                  load_use
);

  logic rd_nonzero_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rd_nonzero_s = (id_ex_rd != {REG_ADDR_W{1'b0}});
  assign rs1_hit_s    = id_uses_rs1 && (id_rs1 == id_ex_rd);
  assign rs2_hit_s    = id_uses_rs2 && (id_rs2 == id_ex_rd);
  assign load_use     = id_ex_mem_read && rd_nonzero_s && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use stall, branch flush and MDU
// start/done handshake with watchdog. Statistics counters under PIPE_CTRL_STATS_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu_op,
  input  logic                  mdu_done,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  id_ex_we,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_bubble,
  output logic                  mdu_start,
  output logic                  mdu_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [WD_W-1:0] wdog_r;
  logic [WD_W-1:0] wdog_nxt_s;
  logic            err_set_s;
  logic            load_use_s;
  logic            mdu_err_r;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .load_use       (load_use_s)
  );

  // State, watchdog and sticky abort flag registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= RUN;
      wdog_r    <= WD_ZERO;
      mdu_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      wdog_r    <= wdog_nxt_s;
      mdu_err_r <= mdu_err_r | err_set_s;
    end
  end

  assign mdu_err = mdu_err_r;

  // Next-state and same-cycle pipeline control outputs
  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_start     = 1'b0;
    state_nxt_s   = state_r;
    wdog_nxt_s    = wdog_r;
    err_set_s     = 1'b0;
    if (!arst_n) begin
      // Freeze the pipeline and fill it with NOPs while reset is held
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
      state_nxt_s   = RUN;
      wdog_nxt_s    = WD_ZERO;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_mdu_op) begin
            mdu_start     = 1'b1;
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
            state_nxt_s   = MDU_WAIT;
            wdog_nxt_s    = WD_ZERO;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_s) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            state_nxt_s = RUN;
          end else if (wdog_r == WD_MAX) begin
            // Abort: release the pipeline but drop the missing result
            ex_mem_bubble = 1'b1;
            err_set_s     = 1'b1;
            state_nxt_s   = RUN;
          end else begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_ex_we      = 1'b0;
            ex_mem_bubble = 1'b1;
            wdog_nxt_s    = wdog_r + WD_ONE;
          end
        end
        default: begin
          state_nxt_s = RUN;
          wdog_nxt_s  = WD_ZERO;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating stall/flush statistics counters
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_r <= CNT_ZERO;
      flush_cnt_r <= CNT_ZERO;
    end else begin
      if (!pc_we && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (if_id_flush && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
